// File: rtl/wave_generator.sv
// rtl/wave_generator.sv - triangle/saw/square sample generator driving an R2R ladder and a PWM output
// Waveform parameters are latched per period so mid-period input changes never distort a cycle.
module wave_generator #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] divider,
  input  logic [WIDTH-1:0]     step,
  output logic [WIDTH-1:0]     r2r_out,
  output logic                 pwm_out,
  output logic                 cycle_start
);

  typedef enum logic [1:0] {
    TRIANGLE = 2'b00,
    SAW_UP   = 2'b01,
    SAW_DOWN = 2'b10,
    SQUARE   = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  logic [DIV_WIDTH-1:0] r_tick_cnt;
  logic [WIDTH-1:0]     r_pwm_cnt;
  logic [WIDTH-1:0]     r_ramp;
  logic [WIDTH-1:0]     r_step_q;
  logic [WIDTH-1:0]     r_r2r;
  logic                 r_pwm;
  logic                 r_cycle_start;
  logic                 r_dir;
  mode_e                r_mode_q;

  mode_e                w_mode_in;
  logic [WIDTH-1:0]     w_step_in;
  logic                 w_dir_load;
  logic                 w_tick;
  logic [WIDTH:0]       w_ramp_x;
  logic [WIDTH:0]       w_step_x;
  logic [WIDTH:0]       w_headroom;
  logic [WIDTH-1:0]     w_ramp_add;
  logic [WIDTH-1:0]     w_ramp_sub;
  logic [WIDTH-1:0]     w_ramp_nxt;
  logic [WIDTH-1:0]     w_sample_nxt;
  logic                 w_dir_nxt;
  logic                 w_wrap;

  assign w_mode_in  = mode_e'(mode);
  assign w_step_in  = (step == '0) ? WIDTH'(1) : step;
  assign w_dir_load = (w_mode_in != SAW_DOWN);
  assign w_tick     = (r_tick_cnt >= divider);

  // Bounds are compared one bit wider; the narrow add/sub is only selected when it cannot wrap.
  assign w_ramp_x   = {1'b0, r_ramp};
  assign w_step_x   = {1'b0, r_step_q};
  assign w_headroom = {1'b0, MAX} - w_step_x;
  assign w_ramp_add = r_ramp + r_step_q;
  assign w_ramp_sub = r_ramp - r_step_q;

  always_comb begin
    w_ramp_nxt = r_ramp;
    w_dir_nxt  = r_dir;
    w_wrap     = 1'b0;
    case (r_mode_q)
      TRIANGLE: begin
        if (r_dir) begin
          if (w_ramp_x >= w_headroom) begin
            w_ramp_nxt = MAX;
            w_dir_nxt  = 1'b0;
          end else begin
            w_ramp_nxt = w_ramp_add;
          end
        end else begin
          if (r_ramp <= r_step_q) begin
            w_ramp_nxt = '0;
            w_dir_nxt  = 1'b1;
            w_wrap     = 1'b1;
          end else begin
            w_ramp_nxt = w_ramp_sub;
          end
        end
      end
      SAW_DOWN: begin
        w_dir_nxt = 1'b0;
        if (r_ramp < r_step_q) begin
          w_ramp_nxt = MAX;
          w_wrap     = 1'b1;
        end else begin
          w_ramp_nxt = w_ramp_sub;
        end
      end
      default: begin
        w_dir_nxt = 1'b1;
        if (w_ramp_x > w_headroom) begin
          w_ramp_nxt = '0;
          w_wrap     = 1'b1;
        end else begin
          w_ramp_nxt = w_ramp_add;
        end
      end
    endcase
    w_sample_nxt = (r_mode_q == SQUARE) ? {WIDTH{w_ramp_nxt[WIDTH-1]}} : w_ramp_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt    <= '0;
      r_pwm_cnt     <= '0;
      r_ramp        <= '0;
      r_r2r         <= '0;
      r_pwm         <= 1'b0;
      r_cycle_start <= 1'b0;
      r_dir         <= 1'b1;
      r_mode_q      <= w_mode_in;
      r_step_q      <= w_step_in;
    end else if (!enable) begin
      r_tick_cnt    <= '0;
      r_pwm_cnt     <= '0;
      r_ramp        <= '0;
      r_r2r         <= '0;
      r_pwm         <= 1'b0;
      r_cycle_start <= 1'b0;
      r_dir         <= w_dir_load;
      r_mode_q      <= w_mode_in;
      r_step_q      <= w_step_in;
    end else begin
      r_pwm_cnt     <= r_pwm_cnt + WIDTH'(1);
      r_pwm         <= (r_pwm_cnt < r_r2r);
      r_cycle_start <= 1'b0;
      if (w_tick) begin
        r_tick_cnt    <= '0;
        r_ramp        <= w_ramp_nxt;
        r_dir         <= w_dir_nxt;
        r_r2r         <= w_sample_nxt;
        r_cycle_start <= w_wrap;
        // Period boundary: pick up new mode/step; ramp carries over into the new shape.
        if (w_wrap) begin
          r_mode_q <= w_mode_in;
          r_step_q <= w_step_in;
          r_dir    <= w_dir_load;
        end
      end else begin
        r_tick_cnt <= r_tick_cnt + DIV_WIDTH'(1);
      end
    end
  end

  assign r2r_out     = r_r2r;
  assign pwm_out     = r_pwm;
  assign cycle_start = r_cycle_start;

endmodule
